soc_system_memtest_master: RTL and testbench
============================================

SOC_SYSTEM_MEMTEST_MASTER -- requirements
Module: soc_system_memtest_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning word-address width of the target memory.
REQ-002 SHALL have parameter DEPTH, default 12288, meaning number of 32-bit words in the target.
REQ-003 SHALL have parameter RD_LATENCY, default 1, meaning fixed cycles from accepted read to valid readdata.
REQ-004 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse launching a test.
REQ-007 SHALL have port base  in  ADDR_W  first word address.
REQ-008 SHALL have port length  in  ADDR_W+1  word count.
REQ-009 SHALL have port seed  in  32  pattern seed.
REQ-010 SHALL have port busy  out  1  test in progress.
REQ-011 SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port error  out  1  sticky: mismatch or range fault in last test.
REQ-013 SHALL have port err_count  out  16  mismatching words, saturating.
REQ-014 SHALL have port err_addr  out  ADDR_W  address of first mismatch.
REQ-015 SHALL have ports address out ADDR_W, byteenable out 4, chipselect out 1, write out 1, read out 1, writedata out 32, readdata in 32, waitrequest in 1 (Avalon-MM master, word addressed).

Function
REQ-016 SHALL use states IDLE, WRITE, READ, RWAIT, DONE.
REQ-017 SHALL in IDLE accept start only when busy=0; start while busy SHALL be ignored.
REQ-018 SHALL on start with length=0 go to DONE without bus activity, error=0.
REQ-019 SHALL on start with base+length > DEPTH set error=1, err_count=0, go to DONE without bus activity.
REQ-020 SHALL otherwise clear error/err_count, load index=0, pattern=seed, enter WRITE.
REQ-021 SHALL in WRITE drive chipselect=1, write=1, byteenable=4'hF, address=base+index, writedata=pattern.
REQ-022 SHALL hold all bus outputs stable while waitrequest=1; a transfer is accepted on a cycle with waitrequest=0.
REQ-023 SHALL on each accepted write advance index and pattern; after write of index length-1, reset index/pattern to start values and enter READ.
REQ-024 SHALL in READ drive chipselect=1, read=1, address=base+index; on acceptance enter RWAIT.
REQ-025 SHALL in RWAIT count RD_LATENCY cycles, then compare readdata to expected pattern: one outstanding read maximum.
REQ-026 SHALL on mismatch set error=1, increment err_count (saturate at 16'hFFFF), and latch err_addr only for the first mismatch.
REQ-027 SHALL after comparing index length-1 enter DONE, else advance and return to READ.
REQ-028 SHALL pulse done for exactly one cycle in DONE, then return to IDLE; busy=1 in all states except IDLE.
REQ-029 SHALL deassert chipselect, read, write in IDLE, RWAIT, DONE.
REQ-030 SHALL compute address in ADDR_W bits; REQ-019 guarantees no wrap.

Reset
REQ-031 SHALL on reset (any time, including mid-transfer) force IDLE, busy=0, done=0, error=0, err_count=0, err_addr=0, chipselect=0, read=0, write=0, address=0, writedata=0, byteenable=0.

Configuration
REQ-032 SHALL with MEMTEST_LFSR_EN defined advance pattern as 32-bit Galois LFSR, taps 32'h80200003 (seed 0 replaced by 32'h1).
REQ-033 SHALL without MEMTEST_LFSR_EN advance pattern as pattern+1 (mod 2^32).

Structure
REQ-034 SHALL place state enum, LFSR tap constant, and pattern-step function in package soc_system_memtest_pkg.
REQ-035 SHALL isolate pattern generation in sub-module soc_system_memtest_patgen (load, step, value), instantiated once; the expected-value and write-value streams SHALL reuse it via reload.

Verification
REQ-036 SHALL verify: base=0, length=4, seed=32'h10, no LFSR, ideal memory -> writes 10,11,12,13 to 0..3, done after readback, error=0.
REQ-037 SHALL verify: waitrequest high 3 cycles on second write -> address/writedata stable throughout, no skipped or duplicated word.
REQ-038 SHALL verify: memory model corrupts word 5 and 7 (base=0, length=8) -> error=1, err_count=2, err_addr=5.
REQ-039 SHALL verify: base=12280, length=9 -> error=1, no chipselect, done one cycle later; length=0 -> done, error=0.
REQ-040 SHALL verify: reset asserted during READ -> all outputs to reset values next edge; new start then runs cleanly.
REQ-041 SHALL verify: with MEMTEST_LFSR_EN, seed=0, length=3 -> writedata 1, 32'h80200003 step sequence matches package function.

Source files
------------

// File: rtl/soc_system_memtest_pkg.sv
// soc_system_memtest_pkg: FSM states and the test-pattern sequence shared by the memtest master.
// MEMTEST_LFSR_EN selects a 32-bit Galois LFSR instead of an incrementing pattern.
package soc_system_memtest_pkg;
    typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, DONE} state_t;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    function automatic logic [31:0] pat_seed(input logic [31:0] s);
`ifdef MEMTEST_LFSR_EN
        return (s == 32'h0) ? 32'h1 : s;
`else
        return s;
`endif
    endfunction
    function automatic logic [31:0] pat_step(input logic [31:0] p);
`ifdef MEMTEST_LFSR_EN
        return p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
`else
        return p + 32'h1;
`endif
    endfunction
endpackage

// File: rtl/soc_system_memtest_master_if.sv
// soc_system_memtest_master_if: word-addressed Avalon-MM bus between the memtest master and its target.
interface soc_system_memtest_master_if #(parameter int ADDR_W = 14);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic              read;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              waitrequest;
    modport master (output address, byteenable, chipselect, write, read, writedata,
                    input readdata, waitrequest);
    modport slave  (input address, byteenable, chipselect, write, read, writedata,
                    output readdata, waitrequest);
endinterface

// File: rtl/soc_system_memtest_patgen.sv
// soc_system_memtest_patgen: pattern register; load restarts the sequence from seed, step advances it.
module soc_system_memtest_patgen
    import soc_system_memtest_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] value
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) value <= '0;
        else       value <= load ? pat_seed(seed) : step ? pat_step(value) : value;
    end
endmodule

// File: rtl/soc_system_memtest_master.sv
// soc_system_memtest_master: writes a pattern over a memory window, reads it back and counts mismatches.
// Define MEMTEST_LFSR_EN for LFSR patterns; default is an incrementing pattern.
module soc_system_memtest_master
    import soc_system_memtest_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 12288,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base,
    input  logic [ADDR_W:0]             length,
    input  logic [31:0]                 seed,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [15:0]                 err_count,
    output logic [ADDR_W-1:0]           err_addr,
    soc_system_memtest_master_if.master bus
);
    localparam int LW = $clog2(RD_LATENCY + 1) + 1;
    state_t            state, nxt;
    logic [ADDR_W-1:0] base_q, cur_addr;
    logic [ADDR_W:0]   len_q, index;
    logic [31:0]       seed_q, pattern;
    logic [LW-1:0]     lat_cnt;
    logic [ADDR_W+1:0] span;
    logic              pg_load, pg_step, acc, last, lat_done, fault, mismatch, xfer;

    assign span     = (ADDR_W+2)'(base) + (ADDR_W+2)'(length);
    assign fault    = span > (ADDR_W+2)'(DEPTH);
    assign acc      = !bus.waitrequest;
    assign last     = index == len_q - (ADDR_W+1)'(1);
    assign lat_done = lat_cnt == LW'(RD_LATENCY);
    assign cur_addr = base_q + index[ADDR_W-1:0];
    assign mismatch = bus.readdata != pattern;
    assign xfer     = state == WRITE || state == READ;

    // one generator serves both passes: reloaded from the captured seed before readback
    soc_system_memtest_patgen u_patgen (
        .clk   (clk),
        .reset (reset),
        .load  (pg_load),
        .step  (pg_step),
        .seed  (state == IDLE ? seed : seed_q),
        .value (pattern)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt     = state;
        pg_load = 1'b0;
        pg_step = 1'b0;
        case (state)
            IDLE:    if (start) begin
                         nxt     = (length == '0 || fault) ? DONE : WRITE;
                         pg_load = 1'b1;
                     end
            WRITE:   if (acc) begin
                         nxt     = last ? READ : WRITE;
                         pg_load = last;
                         pg_step = !last;
                     end
            READ:    nxt = acc ? RWAIT : READ;
            RWAIT:   if (lat_done) begin
                         nxt     = last ? DONE : READ;
                         pg_step = 1'b1;
                     end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy           = state != IDLE;
    assign done           = state == DONE;
    assign bus.chipselect = xfer;
    assign bus.write      = state == WRITE;
    assign bus.read       = state == READ;
    assign bus.byteenable = xfer ? 4'hF : 4'h0;
    assign bus.address    = xfer ? cur_addr : '0;
    assign bus.writedata  = state == WRITE ? pattern : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            index     <= '0;
            lat_cnt   <= '0;
            error     <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_q    <= base;
                len_q     <= length;
                seed_q    <= seed;
                index     <= '0;
                error     <= fault && length != '0;
                err_count <= '0;
                err_addr  <= '0;
            end
            if (state == WRITE && acc) index <= last ? '0 : index + 1'b1;
            if (state == READ && acc) lat_cnt <= LW'(1);
            if (state == RWAIT) begin
                lat_cnt <= lat_done ? lat_cnt : lat_cnt + 1'b1;
                if (lat_done) begin
                    index <= index + 1'b1;
                    if (mismatch) begin
                        error     <= 1'b1;
                        err_count <= &err_count ? err_count : err_count + 1'b1;
                        if (!error) err_addr <= cur_addr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_soc_system_memtest_master.sv
// tb_soc_system_memtest_master: table-driven checks of the memtest master against a 64-word memory model.
module tb_soc_system_memtest_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base = '0;
    logic [14:0] length = '0;
    logic [31:0] seed = '0;
    logic        busy, done, error;
    logic [15:0] err_count;
    logic [13:0] err_addr;

    soc_system_memtest_master_if #(.ADDR_W(14)) bus ();

    soc_system_memtest_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .length    (length),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_count (err_count),
        .err_addr  (err_addr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] base;
        logic [14:0] len;
        logic [31:0] seed;
        logic [63:0] corrupt;
        logic        exp_err;
        logic [15:0] exp_cnt;
        logic [13:0] exp_addr;
        int          nwr;
    } tv_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] mem [0:63];
    logic [63:0] corrupt = '0;
    logic [13:0] wr_a [0:511];
    logic [31:0] wr_d [0:511];
    int          wr_n = 0;
    int          rd_n = 0;
    int          stall_len = 0;
    int          stall_cnt = 0;
    int          stall_err = 0;
    logic        prev_wait = 1'b0;
    logic [13:0] prev_a = '0;
    logic [31:0] prev_d = '0;

    initial for (int i = 0; i < 64; i++) mem[i] = '0;

    assign bus.waitrequest = bus.chipselect && bus.write && bus.address == 14'd1 && stall_cnt < stall_len;

    always @(posedge clk) begin
        if (bus.chipselect && !bus.waitrequest) begin
            if (bus.write) begin
                mem[bus.address[5:0]] <= bus.writedata;
                wr_a[wr_n % 512] <= bus.address;
                wr_d[wr_n % 512] <= bus.writedata;
                wr_n <= wr_n + 1;
            end
            if (bus.read) begin
                bus.readdata <= mem[bus.address[5:0]] ^ (corrupt[bus.address[5:0]] ? 32'h1 : 32'h0);
                rd_n <= rd_n + 1;
            end
        end
        if (bus.waitrequest) stall_cnt <= stall_cnt + 1;
        if (prev_wait && (bus.address != prev_a || bus.writedata != prev_d)) stall_err <= stall_err + 1;
        prev_wait <= bus.waitrequest;
        prev_a    <= bus.address;
        prev_d    <= bus.writedata;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_pat(input logic [31:0] s, input int i);
        logic [31:0] p;
`ifdef MEMTEST_LFSR_EN
        p = (s == 32'h0) ? 32'h1 : s;
        for (int k = 0; k < i; k++) p = p[0] ? ((p >> 1) ^ 32'h80200003) : (p >> 1);
`else
        p = s + 32'(i);
`endif
        return p;
    endfunction

    task automatic pulse_start(input logic [13:0] b, input logic [14:0] l, input logic [31:0] s);
        @(negedge clk);
        base = b; length = l; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL %s_timeout: no done after %0d cycles", nm, cyc);
        end
    endtask

    task automatic run(input tv_t v, input string nm);
        int cyc, w0, r0, bad;
        w0 = wr_n; r0 = rd_n; corrupt = v.corrupt;
        pulse_start(v.base, v.len, v.seed);
        wait_done(nm, cyc);
        chk({nm, "_error"}, error, v.exp_err);
        chk({nm, "_err_count"}, err_count, v.exp_cnt);
        chk({nm, "_err_addr"}, err_addr, v.exp_addr);
        chk({nm, "_writes"}, wr_n - w0, v.nwr);
        chk({nm, "_reads"}, rd_n - r0, v.nwr);
        if (v.nwr == 0) chk({nm, "_done_latency"}, cyc, 1);
        bad = 0;
        for (int i = 0; i < wr_n - w0 && i < v.nwr; i++)
            if (wr_a[(w0 + i) % 512] != v.base + 14'(i) || wr_d[(w0 + i) % 512] != exp_pat(v.seed, i)) bad++;
        chk({nm, "_write_stream"}, bad, 0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, {done, busy}, 2'b00);
    endtask

    tv_t tv [7];

    initial begin
        int cyc, w0;
        tv[0] = '{14'd0,     15'd4, 32'h10,       64'h0,      1'b0, 16'd0, 14'd0,  4};
        tv[1] = '{14'd0,     15'd8, 32'd100,      64'hA0,     1'b1, 16'd2, 14'd5,  8};
        tv[2] = '{14'd12280, 15'd9, 32'h0,        64'h0,      1'b1, 16'd0, 14'd0,  0};
        tv[3] = '{14'd12280, 15'd8, 32'h7,        64'h0,      1'b0, 16'd0, 14'd0,  8};
        tv[4] = '{14'd3,     15'd0, 32'h1,        64'h0,      1'b0, 16'd0, 14'd0,  0};
        tv[5] = '{14'd20,    15'd5, 32'hFFFFFFFE, 64'h400000, 1'b1, 16'd1, 14'd22, 5};
        tv[6] = '{14'd12287, 15'd1, 32'h3,        64'h0,      1'b0, 16'd0, 14'd0,  1};
        #1;
        chk("reset_outputs", {busy, done, error, err_count, err_addr, bus.chipselect, bus.read,
                              bus.write, bus.address, bus.writedata, bus.byteenable}, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) run(tv[i], $sformatf("vec%0d", i));

        // second write held off for three cycles
        stall_len = stall_cnt + 3;
        run(tv[0], "stall");
        chk("stall_cycles", stall_len - stall_cnt, 0);
        chk("stall_stable", stall_err, 0);
        stall_len = 0;

        // a start while busy must not disturb the running test
        w0 = wr_n; corrupt = '0;
        pulse_start(14'd0, 15'd8, 32'd5);
        @(negedge clk);
        chk("busy_during_test", busy, 1'b1);
        base = 14'd12280; length = 15'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", cyc);
        chk("ignore_error", error, 1'b0);
        chk("ignore_writes", wr_n - w0, 8);

        // asynchronous reset in the middle of the readback pass
        corrupt = 64'h2;
        pulse_start(14'd0, 15'd8, 32'h40);
        cyc = 0;
        while (!(bus.read && bus.address == 14'd3) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_read3", {bus.read, bus.address}, {1'b1, 14'd3});
        chk("pre_reset_err", {error, err_count, err_addr}, {1'b1, 16'd1, 14'd1});
        reset = 1'b1;
        #1;
        chk("midread_reset", {busy, done, error, err_count, err_addr, bus.chipselect, bus.read,
                              bus.write, bus.address, bus.writedata, bus.byteenable}, '0);
        @(negedge clk);
        chk("reset_held", {busy, bus.chipselect}, 2'b00);
        reset = 1'b0;
        run(tv[0], "after_reset");

`ifdef MEMTEST_LFSR_EN
        w0 = wr_n;
        run('{14'd0, 15'd3, 32'h0, 64'h0, 1'b0, 16'd0, 14'd0, 3}, "lfsr");
        chk("lfsr_w0", wr_d[w0 % 512], 32'h1);
        chk("lfsr_w1", wr_d[(w0 + 1) % 512], 32'h80200003);
        chk("lfsr_w2", wr_d[(w0 + 2) % 512], 32'hC0300002);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
